// File: rtl/ifu_fetch_pkg.sv
// Shared widths, reset defaults and the buffered fetch entry type for the fetch unit.
package ifu_pkg;
  localparam int unsigned XLEN    = 64;
  localparam int unsigned INSTR_W = 32;
  localparam int unsigned DEFAULT_DEPTH = 4;
  localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 64'h0000_0000_8000_0000;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Occupancy counters must represent 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction
endpackage

// File: rtl/ifu_fetch_if.sv
// Redirect, instruction-memory and decode-side handshake signals of the fetch unit.
interface ifu_fetch_if;
  import ifu_pkg::*;

  logic               redirect_valid;
  logic [XLEN-1:0]    redirect_pc;
  logic               mem_req_valid;
  logic               mem_req_ready;
  logic [XLEN-1:0]    mem_req_addr;
  logic               mem_rsp_valid;
  logic [INSTR_W-1:0] mem_rsp_data;
  logic               instr_valid;
  logic               instr_ready;
  logic [INSTR_W-1:0] instr;
  logic [XLEN-1:0]    instr_pc;

  modport master (
    input  redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
    output mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc
  );

  modport slave (
    output redirect_valid, redirect_pc, mem_req_ready, mem_rsp_valid, mem_rsp_data, instr_ready,
    input  mem_req_valid, mem_req_addr, instr_valid, instr, instr_pc
  );
endinterface

// File: rtl/ifu_fetch_fifo.sv
// Synchronous circular FIFO with flush; flush wins over push, pops on empty are ignored.
module fetch_fifo import ifu_pkg::*; #(
  parameter int unsigned DEPTH = DEFAULT_DEPTH,
  parameter type T = fetch_entry_t,
  localparam int unsigned CW = cnt_width(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_flush,
  input  logic          i_push,
  input  T              i_data,
  input  logic          i_pop,
  output T              o_data,
  output logic [CW-1:0] o_count
);
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  T              r_mem [DEPTH];
  logic [AW-1:0] r_rd;
  logic [AW-1:0] r_wr;
  logic [CW-1:0] r_count;
  logic          w_push;
  logic          w_pop;

  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
  endfunction

  assign w_push  = i_push & ~i_flush & (r_count != CW'(DEPTH));
  assign w_pop   = i_pop & ~i_flush & (r_count != '0);
  assign o_data  = r_mem[r_rd];
  assign o_count = r_count;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (!rst || i_flush) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wr <= ptr_next(r_wr);
      if (w_pop)  r_rd <= ptr_next(r_rd);
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/ifu_fetch.sv
// Fetch unit: credit-limited sequential requests, in-order response buffering, redirect flush.
module ifu_fetch import ifu_pkg::*; #(
  parameter int unsigned     DEPTH    = DEFAULT_DEPTH,
  parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input logic         clk,
  input logic         rst,
  ifu_fetch_if.master bus
);
  localparam int unsigned CW = cnt_width(DEPTH);

  logic [XLEN-1:0] r_fetch_pc;
  logic [CW-1:0]   r_outstanding;
  logic [CW-1:0]   r_stale;
  logic [CW-1:0]   w_count;
  logic [CW-1:0]   w_tag_count;
  logic [XLEN-1:0] w_tag_pc;
  logic [CW:0]     w_inflight;
  logic            w_req_valid;
  logic            w_fire;
  logic            w_rsp_live;
  logic            w_rsp_stale;
  logic            w_instr_valid;
  logic            w_pop;
  fetch_entry_t    w_buf_in;
  fetch_entry_t    w_head;

  always_comb begin
    w_inflight    = {1'b0, r_outstanding} + {1'b0, w_count};
    w_req_valid   = rst & ~bus.redirect_valid & (32'(w_inflight) < DEPTH);
    w_fire        = w_req_valid & bus.mem_req_ready;
    // Stale responses belong to requests whose tags were flushed, so they never pop the tag queue.
    w_rsp_live    = bus.mem_rsp_valid & (r_stale == '0) & (w_tag_count != '0);
    w_rsp_stale   = bus.mem_rsp_valid & (r_stale != '0);
    w_buf_in.pc    = w_tag_pc;
    w_buf_in.instr = bus.mem_rsp_data;
    w_instr_valid = (w_count != '0);
    w_pop         = w_instr_valid & bus.instr_ready;
  end

  assign bus.mem_req_valid = w_req_valid;
  assign bus.mem_req_addr  = r_fetch_pc;
  assign bus.instr_valid   = w_instr_valid;
  assign bus.instr         = w_head.instr;
  assign bus.instr_pc      = w_head.pc;

  fetch_fifo #(.DEPTH(DEPTH), .T(logic [XLEN-1:0])) u_tag_q (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.redirect_valid),
    .i_push  (w_fire),
    .i_data  (r_fetch_pc),
    .i_pop   (w_rsp_live),
    .o_data  (w_tag_pc),
    .o_count (w_tag_count)
  );

  fetch_fifo #(.DEPTH(DEPTH), .T(fetch_entry_t)) u_instr_q (
    .clk     (clk),
    .rst     (rst),
    .i_flush (bus.redirect_valid),
    .i_push  (w_rsp_live),
    .i_data  (w_buf_in),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_count (w_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_fetch_pc    <= RESET_PC;
      r_outstanding <= '0;
      r_stale       <= '0;
    end else begin
      if (bus.redirect_valid)
        r_fetch_pc <= {bus.redirect_pc[XLEN-1:2], 2'b00};
      else if (w_fire)
        r_fetch_pc <= r_fetch_pc + 64'd4;

      r_outstanding <= r_outstanding + CW'(w_fire) - CW'(bus.mem_rsp_valid);

      if (bus.redirect_valid)
        r_stale <= r_outstanding - CW'(bus.mem_rsp_valid);
      else if (w_rsp_stale)
        r_stale <= r_stale - CW'(1);
    end
  end
endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: latency-configurable in-order memory model plus delivery monitor.
module tb_ifu_fetch;
  import ifu_pkg::*;

  logic clk;
  logic rst;
  int unsigned runs;
  int unsigned fails;
  int unsigned cyc;
  int unsigned lat;

  typedef struct {
    int unsigned     due;
    logic [XLEN-1:0] addr;
  } mreq_t;

  mreq_t           mq[$];
  logic [XLEN-1:0] fire_q[$];
  logic [XLEN-1:0] dpc_q[$];
  logic [31:0]     dins_q[$];

  ifu_fetch_if bus();

  ifu_fetch #(.DEPTH(4), .RESET_PC(64'h0000_0000_8000_0000)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(input logic [XLEN-1:0] a);
    return a[31:0] ^ 32'h1357_9bdf;
  endfunction

  // In-order memory: a request accepted in cycle C answers in cycle C+lat.
  always @(posedge clk) begin
    if (!rst) begin
      mq.delete();
      bus.mem_rsp_valid <= 1'b0;
      bus.mem_rsp_data  <= '0;
    end else begin
      if (bus.mem_req_valid && bus.mem_req_ready)
        mq.push_back('{cyc + lat, bus.mem_req_addr});
      if (mq.size() > 0 && mq[0].due <= cyc + 1) begin
        bus.mem_rsp_valid <= 1'b1;
        bus.mem_rsp_data  <= mem_word(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        bus.mem_rsp_valid <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  always @(posedge clk) begin
    if (!rst) begin
      fire_q.delete();
      dpc_q.delete();
      dins_q.delete();
    end else begin
      if (bus.mem_req_valid && bus.mem_req_ready) fire_q.push_back(bus.mem_req_addr);
      if (bus.instr_valid && bus.instr_ready) begin
        dpc_q.push_back(bus.instr_pc);
        dins_q.push_back(bus.instr);
      end
    end
  end

  // Leaves the caller 1ns into cycle 0, the first cycle with rst high.
  task automatic do_reset(input int unsigned l, input logic irdy, input logic mrdy);
    @(negedge clk);
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_req_ready = mrdy;
    bus.instr_ready = irdy;
    lat = l;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    #1;
  endtask

  task automatic test_reset;
    @(negedge clk);
    rst = 1'b0;
    bus.instr_ready = 1'b1;
    bus.mem_req_ready = 1'b1;
    lat = 1;
    repeat (2) @(negedge clk);
    #1;
    runs++; if (bus.mem_req_valid !== 1'b0) begin $display("FAIL reset_req_valid: got %b want 0", bus.mem_req_valid); fails++; end
    runs++; if (bus.instr_valid !== 1'b0) begin $display("FAIL reset_instr_valid: got %b want 0", bus.instr_valid); fails++; end
    rst = 1'b1;
    #1;
    runs++; if (bus.mem_req_valid !== 1'b1) begin $display("FAIL reset_first_req: got %b want 1", bus.mem_req_valid); fails++; end
    runs++; if (bus.mem_req_addr !== 64'h8000_0000) begin $display("FAIL reset_first_addr: got %h want 80000000", bus.mem_req_addr); fails++; end
  endtask

  task automatic test_stream;
    logic [XLEN-1:0] exp_pc;
    do_reset(1, 1'b1, 1'b1);
    runs++; if (bus.instr_valid !== 1'b0) begin $display("FAIL stream_c0_valid: got %b want 0", bus.instr_valid); fails++; end
    @(negedge clk); #1;
    runs++; if (bus.instr_valid !== 1'b0) begin $display("FAIL stream_c1_valid: got %b want 0", bus.instr_valid); fails++; end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      exp_pc = 64'h8000_0000 + 64'(4 * i);
      runs++; if (bus.instr_valid !== 1'b1) begin $display("FAIL stream_valid_%0d: got %b want 1", i, bus.instr_valid); fails++; end
      runs++; if (bus.instr_pc !== exp_pc) begin $display("FAIL stream_pc_%0d: got %h want %h", i, bus.instr_pc, exp_pc); fails++; end
      runs++; if (bus.instr !== mem_word(exp_pc)) begin $display("FAIL stream_instr_%0d: got %h want %h", i, bus.instr, mem_word(exp_pc)); fails++; end
    end
  endtask

  task automatic test_backpressure;
    logic [XLEN-1:0] exp_pc;
    do_reset(1, 1'b0, 1'b1);
    repeat (9) @(negedge clk);
    #1;
    runs++; if (fire_q.size() !== 4) begin $display("FAIL bp_req_count: got %0d want 4", fire_q.size()); fails++; end
    runs++; if (bus.mem_req_valid !== 1'b0) begin $display("FAIL bp_req_stopped: got %b want 0", bus.mem_req_valid); fails++; end
    runs++; if (bus.instr_pc !== 64'h8000_0000) begin $display("FAIL bp_head_stable: got %h want 80000000", bus.instr_pc); fails++; end
    bus.instr_ready = 1'b1;
    repeat (8) @(negedge clk);
    #1;
    runs++;
    if (dpc_q.size() < 4) begin
      $display("FAIL bp_drain_count: got %0d want >=4", dpc_q.size()); fails++;
    end else begin
      for (int i = 0; i < 4; i++) begin
        exp_pc = 64'h8000_0000 + 64'(4 * i);
        runs++; if (dpc_q[i] !== exp_pc) begin $display("FAIL bp_drain_pc_%0d: got %h want %h", i, dpc_q[i], exp_pc); fails++; end
      end
    end
    runs++;
    if (fire_q.size() < 5) begin $display("FAIL bp_resume: got %0d requests want >=5", fire_q.size()); fails++; end
    else if (fire_q[4] !== 64'h8000_0010) begin $display("FAIL bp_resume_addr: got %h want 80000010", fire_q[4]); fails++; end
  endtask

  task automatic test_redirect_latency;
    do_reset(3, 1'b1, 1'b1);
    @(negedge clk);
    @(negedge clk);
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h1002;
    #1;
    runs++; if (bus.mem_req_valid !== 1'b0) begin $display("FAIL redir_no_issue: got %b want 0", bus.mem_req_valid); fails++; end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    runs++; if (dut.r_stale !== 3'd2) begin $display("FAIL redir_stale: got %0d want 2", dut.r_stale); fails++; end
    runs++; if (bus.mem_req_valid !== 1'b1) begin $display("FAIL redir_req_valid: got %b want 1", bus.mem_req_valid); fails++; end
    runs++; if (bus.mem_req_addr !== 64'h1000) begin $display("FAIL redir_addr: got %h want 1000", bus.mem_req_addr); fails++; end
    repeat (6) @(negedge clk);
    #1;
    runs++;
    if (dpc_q.size() < 2) begin
      $display("FAIL redir_delivered: got %0d want >=2", dpc_q.size()); fails++;
    end else begin
      runs++; if (dpc_q[0] !== 64'h1000) begin $display("FAIL redir_first_pc: got %h want 1000", dpc_q[0]); fails++; end
      runs++; if (dins_q[0] !== mem_word(64'h1000)) begin $display("FAIL redir_first_instr: got %h want %h", dins_q[0], mem_word(64'h1000)); fails++; end
      runs++; if (dpc_q[1] !== 64'h1004) begin $display("FAIL redir_second_pc: got %h want 1004", dpc_q[1]); fails++; end
    end
    runs++; if (dut.r_stale !== 3'd0) begin $display("FAIL redir_stale_drained: got %0d want 0", dut.r_stale); fails++; end
  endtask

  task automatic test_req_stall;
    do_reset(1, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      runs++; if (bus.mem_req_valid !== 1'b1) begin $display("FAIL stall_valid_%0d: got %b want 1", i, bus.mem_req_valid); fails++; end
      runs++; if (bus.mem_req_addr !== 64'h8000_0000) begin $display("FAIL stall_addr_%0d: got %h want 80000000", i, bus.mem_req_addr); fails++; end
      @(negedge clk); #1;
    end
    bus.mem_req_ready = 1'b1;
    runs++; if (fire_q.size() !== 0) begin $display("FAIL stall_no_accept: got %0d want 0", fire_q.size()); fails++; end
    @(negedge clk); #1;
    runs++; if (bus.mem_req_addr !== 64'h8000_0004) begin $display("FAIL stall_advance: got %h want 80000004", bus.mem_req_addr); fails++; end
    runs++; if (fire_q.size() !== 1) begin $display("FAIL stall_one_accept: got %0d want 1", fire_q.size()); fails++; end
  endtask

  task automatic test_redirect_collision;
    do_reset(1, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    #1;
    runs++; if (bus.instr_pc !== 64'h8000_0004) begin $display("FAIL coll_head_pc: got %h want 80000004", bus.instr_pc); fails++; end
    bus.redirect_valid = 1'b1;
    bus.redirect_pc = 64'h2000;
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    #1;
    runs++; if (dut.r_stale !== 3'd0) begin $display("FAIL coll_stale: got %0d want 0", dut.r_stale); fails++; end
    runs++; if (bus.instr_valid !== 1'b0) begin $display("FAIL coll_flushed: got %b want 0", bus.instr_valid); fails++; end
    runs++; if (bus.mem_req_addr !== 64'h2000) begin $display("FAIL coll_addr: got %h want 2000", bus.mem_req_addr); fails++; end
    repeat (4) @(negedge clk);
    #1;
    runs++;
    if (dpc_q.size() < 3) begin
      $display("FAIL coll_delivered: got %0d want >=3", dpc_q.size()); fails++;
    end else begin
      runs++; if (dpc_q[0] !== 64'h8000_0000) begin $display("FAIL coll_pc0: got %h want 80000000", dpc_q[0]); fails++; end
      runs++; if (dpc_q[1] !== 64'h8000_0004) begin $display("FAIL coll_pc1: got %h want 80000004", dpc_q[1]); fails++; end
      runs++; if (dpc_q[2] !== 64'h2000) begin $display("FAIL coll_pc2: got %h want 2000", dpc_q[2]); fails++; end
    end
  endtask

  task automatic test_reset_midstream;
    do_reset(1, 1'b0, 1'b1);
    repeat (4) @(negedge clk);
    #1;
    runs++; if (bus.instr_pc !== 64'h8000_0000) begin $display("FAIL mid_head_pc: got %h want 80000000", bus.instr_pc); fails++; end
    rst = 1'b0;
    @(negedge clk); #1;
    runs++; if (bus.instr_valid !== 1'b0) begin $display("FAIL mid_instr_valid: got %b want 0", bus.instr_valid); fails++; end
    runs++; if (bus.mem_req_valid !== 1'b0) begin $display("FAIL mid_req_valid: got %b want 0", bus.mem_req_valid); fails++; end
    rst = 1'b1;
    bus.instr_ready = 1'b1;
    #1;
    runs++; if (bus.mem_req_addr !== 64'h8000_0000) begin $display("FAIL mid_restart_addr: got %h want 80000000", bus.mem_req_addr); fails++; end
    repeat (3) @(negedge clk);
    #1;
    runs++;
    if (dpc_q.size() < 1) begin $display("FAIL mid_delivered: got %0d want >=1", dpc_q.size()); fails++; end
    else if (dpc_q[0] !== 64'h8000_0000) begin $display("FAIL mid_first_pc: got %h want 80000000", dpc_q[0]); fails++; end
  endtask

  initial begin
    runs = 0;
    fails = 0;
    cyc = 0;
    lat = 1;
    rst = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc = '0;
    bus.mem_req_ready = 1'b1;
    bus.instr_ready = 1'b0;
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_latency();
    test_req_stall();
    test_redirect_collision();
    test_reset_midstream();
    $display("[TB] %0d tests run, %0d failed", runs, fails);
    $finish;
  end
endmodule
